// File: rtl/am29xx_slice.sv
// am29xx_slice: 4-bit Am2901-style ALU slice plus Am2909/Am2911-style
// microprogram sequencer slice. All outputs are combinational.
// Build option: define SEQ_OR_INPUTS_EN for Am2909 behaviour (AR loads from
// seq_rin, seq_orin ORed into seq_y); left undefined the sequencer behaves as
// an Am2911 (AR loads from seq_din, seq_rin/seq_orin ignored).
module am29xx_slice (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] alu_din,
  input  logic [3:0] alu_a,
  input  logic [3:0] alu_b,
  input  logic [2:0] alu_src,
  input  logic [2:0] alu_op,
  input  logic [2:0] alu_dest,
  input  logic       alu_cin,
  output logic [3:0] alu_y,
  output logic       alu_cout,
  output logic       alu_f0,
  output logic       alu_f3,
  output logic       alu_ovr,
  input  logic       q0_in,
  input  logic       q3_in,
  input  logic       ram0_in,
  input  logic       ram3_in,
  output logic       q0_out,
  output logic       q3_out,
  output logic       ram0_out,
  output logic       ram3_out,
  input  logic [3:0] seq_din,
  input  logic [3:0] seq_rin,
  input  logic [3:0] seq_orin,
  input  logic       seq_s0,
  input  logic       seq_s1,
  input  logic       seq_zero_n,
  input  logic       seq_re_n,
  input  logic       seq_fe_n,
  input  logic       seq_pup,
  input  logic       seq_cin,
  output logic [3:0] seq_y,
  output logic       seq_cout
);

  localparam int unsigned W     = 4;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned SDEPTH = 4;

  // ---------------- ALU state ----------------
  logic [W-1:0] ram [DEPTH];
  logic [W-1:0] q_reg;

  logic [W-1:0] a_data, b_data;
  logic [W-1:0] r_op, s_op, f;
  logic         cout, ovr;
  logic [W-1:0] ram_wdata, q_wdata;
  logic         ram_we, q_we;

  assign a_data = ram[alu_a];
  assign b_data = ram[alu_b];

  // Source operand selection (R,S)
  always_comb begin
    r_op = '0;
    s_op = '0;
    case (alu_src)
      3'd0: begin r_op = a_data;  s_op = q_reg;  end
      3'd1: begin r_op = a_data;  s_op = b_data; end
      3'd2: begin r_op = '0;      s_op = q_reg;  end
      3'd3: begin r_op = '0;      s_op = b_data; end
      3'd4: begin r_op = '0;      s_op = a_data; end
      3'd5: begin r_op = alu_din; s_op = a_data; end
      3'd6: begin r_op = alu_din; s_op = q_reg;  end
      default: begin r_op = alu_din; s_op = '0; end
    endcase
  end

  // ALU function; carry into bit 3 taken from a 3-bit partial sum for overflow
  logic [W-1:0] add_x, add_y;
  logic [W:0]   sum_full;
  logic [W-1:0] sum_low;

  always_comb begin
    add_x = r_op;
    add_y = s_op;
    case (alu_op)
      3'd1:    begin add_x = ~r_op; add_y = s_op;  end
      3'd2:    begin add_x = r_op;  add_y = ~s_op; end
      default: begin add_x = r_op;  add_y = s_op;  end
    endcase
    sum_full = {1'b0, add_x} + {1'b0, add_y} + 5'(alu_cin);
    sum_low  = {1'b0, add_x[2:0]} + {1'b0, add_y[2:0]} + 4'(alu_cin);
    f    = '0;
    cout = 1'b0;
    ovr  = 1'b0;
    case (alu_op)
      3'd0, 3'd1, 3'd2: begin
        f    = sum_full[W-1:0];
        cout = sum_full[W];
        ovr  = sum_low[3] ^ sum_full[W];
      end
      3'd3:    f = r_op | s_op;
      3'd4:    f = r_op & s_op;
      3'd5:    f = ~r_op & s_op;
      3'd6:    f = r_op ^ s_op;
      default: f = ~(r_op ^ s_op);
    endcase
  end

  // Destination decode: write enables, write data, Y mux and shift outputs
  always_comb begin
    ram_we    = 1'b0;
    q_we      = 1'b0;
    ram_wdata = f;
    q_wdata   = f;
    alu_y     = f;
    q0_out    = 1'b0;
    q3_out    = 1'b0;
    ram0_out  = 1'b0;
    ram3_out  = 1'b0;
    case (alu_dest)
      3'd0: q_we = 1'b1;
      3'd1: ;
      3'd2: begin ram_we = 1'b1; alu_y = a_data; end
      3'd3: ram_we = 1'b1;
      3'd4: begin
        ram_we    = 1'b1;
        q_we      = 1'b1;
        ram_wdata = {ram3_in, f[3:1]};
        q_wdata   = {q3_in, q_reg[3:1]};
        ram0_out  = f[0];
        q0_out    = q_reg[0];
      end
      3'd5: begin
        ram_we    = 1'b1;
        ram_wdata = {ram3_in, f[3:1]};
        ram0_out  = f[0];
      end
      3'd6: begin
        ram_we    = 1'b1;
        q_we      = 1'b1;
        ram_wdata = {f[2:0], ram0_in};
        q_wdata   = {q_reg[2:0], q0_in};
        ram3_out  = f[3];
        q3_out    = q_reg[3];
      end
      default: begin
        ram_we    = 1'b1;
        ram_wdata = {f[2:0], ram0_in};
        ram3_out  = f[3];
      end
    endcase
  end

  assign alu_cout = cout;
  assign alu_ovr  = ovr;
  assign alu_f0   = (f == '0);
  assign alu_f3   = f[3];

  // Register file and Q register; reset clears every word
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= '0;
      q_reg <= '0;
    end else begin
      if (ram_we) ram[alu_b] <= ram_wdata;
      if (q_we)   q_reg <= q_wdata;
    end
  end

  // ---------------- Sequencer ----------------
  logic [W-1:0] upc, ar;
  logic [1:0]   sp, sp_inc, sp_dec;
  logic [W-1:0] stack [SDEPTH];
  logic [W-1:0] mux_out, ar_src, or_term;

  assign sp_inc = sp + 2'd1;
  assign sp_dec = sp - 2'd1;

`ifdef SEQ_OR_INPUTS_EN
  assign ar_src  = seq_rin;
  assign or_term = seq_orin;
`else
  logic unused_seq_inputs;
  assign unused_seq_inputs = ^{seq_rin, seq_orin};
  assign ar_src  = seq_din;
  assign or_term = '0;
`endif

  // Address source mux; stack top read before any same-cycle push lands
  always_comb begin
    mux_out = upc;
    case ({seq_s1, seq_s0})
      2'd0:    mux_out = upc;
      2'd1:    mux_out = ar;
      2'd2:    mux_out = stack[sp];
      default: mux_out = seq_din;
    endcase
  end

  assign seq_y    = (mux_out | or_term) & {W{seq_zero_n}};
  assign seq_cout = seq_cin & (seq_y == 4'hF);

  // uPC, AR and stack update; reset overrides all loads and stack ops
  always_ff @(posedge clock) begin
    if (reset) begin
      upc <= '0;
      ar  <= '0;
      sp  <= '0;
      for (int i = 0; i < int'(SDEPTH); i++) stack[i] <= '0;
    end else begin
      upc <= seq_y + 4'(seq_cin);
      if (!seq_re_n) ar <= ar_src;
      if (!seq_fe_n) begin
        if (seq_pup) begin
          sp            <= sp_inc;
          stack[sp_inc] <= upc;
        end else begin
          sp <= sp_dec;
        end
      end
    end
  end

endmodule

// File: tb/tb_am29xx_slice.sv
// Directed bench for am29xx_slice: table of combinational ALU vectors plus
// hand-written multi-cycle sequences for RAM/Q shifts and the sequencer.
module tb_am29xx_slice;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] alu_din, alu_a, alu_b;
  logic [2:0] alu_src, alu_op, alu_dest;
  logic       alu_cin;
  logic [3:0] alu_y;
  logic       alu_cout, alu_f0, alu_f3, alu_ovr;
  logic       q0_in, q3_in, ram0_in, ram3_in;
  logic       q0_out, q3_out, ram0_out, ram3_out;
  logic [3:0] seq_din, seq_rin, seq_orin;
  logic       seq_s0, seq_s1, seq_zero_n, seq_re_n, seq_fe_n, seq_pup, seq_cin;
  logic [3:0] seq_y;
  logic       seq_cout;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  am29xx_slice dut (
    .clock(clock), .reset(reset),
    .alu_din(alu_din), .alu_a(alu_a), .alu_b(alu_b),
    .alu_src(alu_src), .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_f0(alu_f0), .alu_f3(alu_f3), .alu_ovr(alu_ovr),
    .q0_in(q0_in), .q3_in(q3_in), .ram0_in(ram0_in), .ram3_in(ram3_in),
    .q0_out(q0_out), .q3_out(q3_out), .ram0_out(ram0_out), .ram3_out(ram3_out),
    .seq_din(seq_din), .seq_rin(seq_rin), .seq_orin(seq_orin),
    .seq_s0(seq_s0), .seq_s1(seq_s1), .seq_zero_n(seq_zero_n),
    .seq_re_n(seq_re_n), .seq_fe_n(seq_fe_n), .seq_pup(seq_pup), .seq_cin(seq_cin),
    .seq_y(seq_y), .seq_cout(seq_cout)
  );

  typedef struct {
    logic [2:0] src, op, dest;
    logic [3:0] a, b, din;
    logic       cin;
    logic [3:0] y;
    logic [3:0] flags;  // {cout, f0, f3, ovr}
    logic [3:0] sh;     // {q3_out, q0_out, ram3_out, ram0_out}
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_seq_s(input logic [1:0] s);
    seq_s1 = s[1];
    seq_s0 = s[0];
  endtask

  task automatic alu_set(input logic [2:0] src, input logic [2:0] op, input logic [2:0] dest,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] din,
                         input logic cin);
    alu_src = src; alu_op = op; alu_dest = dest;
    alu_a = a; alu_b = b; alu_din = din; alu_cin = cin;
  endtask

  // Load a RAM word through D0 / F->B
  task automatic write_ram(input logic [3:0] addr, input logic [3:0] val);
    alu_set(3'd7, 3'd0, 3'd3, 4'd0, addr, val, 1'b0);
    tick();
    alu_dest = 3'd1;
  endtask

  // Load Q through D0 / F->Q
  task automatic write_q(input logic [3:0] val);
    alu_set(3'd7, 3'd0, 3'd0, 4'd0, 4'd0, val, 1'b0);
    tick();
    alu_dest = 3'd1;
  endtask

  task automatic read_b(input string name, input logic [3:0] addr, input logic [3:0] exp);
    alu_set(3'd3, 3'd0, 3'd1, 4'd0, addr, 4'd0, 1'b0);
    #1 chk(name, alu_y, exp);
  endtask

  task automatic read_q(input string name, input logic [3:0] exp);
    alu_set(3'd2, 3'd0, 3'd1, 4'd0, 4'd0, 4'd0, 1'b0);
    #1 chk(name, alu_y, exp);
  endtask

  logic [3:0] exp_ar, exp_or;

  initial begin
    // Table: RAM[1]=9, RAM[3]=3, RAM[4]=B, Q=8 preloaded before use
    vecs[0]  = '{3'd0, 3'd0, 3'd1, 4'd1, 4'd0, 4'h0, 1'b0, 4'h1, 4'b1001, 4'b0000}; // 9+8
    vecs[1]  = '{3'd1, 3'd2, 3'd1, 4'd3, 4'd3, 4'h0, 1'b1, 4'h0, 4'b1100, 4'b0000}; // 3+~3+1
    vecs[2]  = '{3'd1, 3'd1, 3'd1, 4'd1, 4'd3, 4'h0, 1'b1, 4'hA, 4'b0011, 4'b0000}; // 3-9
    vecs[3]  = '{3'd5, 3'd3, 3'd1, 4'd3, 4'd0, 4'h4, 1'b1, 4'h7, 4'b0000, 4'b0000}; // 4|3
    vecs[4]  = '{3'd6, 3'd4, 3'd1, 4'd0, 4'd0, 4'hC, 1'b0, 4'h8, 4'b0010, 4'b0000}; // C&8
    vecs[5]  = '{3'd0, 3'd5, 3'd1, 4'd4, 4'd0, 4'h0, 1'b0, 4'h0, 4'b0100, 4'b0000}; // ~B&8
    vecs[6]  = '{3'd4, 3'd6, 3'd1, 4'd4, 4'd0, 4'h0, 1'b0, 4'hB, 4'b0010, 4'b0000}; // 0^B
    vecs[7]  = '{3'd2, 3'd7, 3'd1, 4'd0, 4'd0, 4'h0, 1'b0, 4'h7, 4'b0000, 4'b0000}; // ~(0^8)
    vecs[8]  = '{3'd7, 3'd0, 3'd2, 4'd1, 4'd0, 4'h5, 1'b0, 4'h9, 4'b0000, 4'b0000}; // Y=A
    vecs[9]  = '{3'd5, 3'd0, 3'd1, 4'd3, 4'd0, 4'h4, 1'b1, 4'h8, 4'b0011, 4'b0000}; // 4+3+1
    vecs[10] = '{3'd7, 3'd0, 3'd4, 4'd0, 4'd0, 4'hB, 1'b0, 4'hB, 4'b0010, 4'b0001}; // down
    vecs[11] = '{3'd7, 3'd0, 3'd6, 4'd0, 4'd0, 4'hB, 1'b0, 4'hB, 4'b0010, 4'b1010}; // up
    vecs[12] = '{3'd1, 3'd1, 3'd1, 4'd3, 4'd1, 4'h0, 1'b1, 4'h6, 4'b1001, 4'b0000}; // 9-3

`ifdef SEQ_OR_INPUTS_EN
    exp_ar = 4'hA;
    exp_or = 4'h9;
`else
    exp_ar = 4'h6;
    exp_or = 4'h8;
`endif

    reset = 1'b1;
    alu_set(3'd3, 3'd0, 3'd1, 4'd0, 4'd0, 4'd0, 1'b0);
    q0_in = 0; q3_in = 0; ram0_in = 0; ram3_in = 0;
    seq_din = 0; seq_rin = 0; seq_orin = 0;
    set_seq_s(2'd0);
    seq_zero_n = 1; seq_re_n = 1; seq_fe_n = 1; seq_pup = 0; seq_cin = 0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    #1 chk("rst_alu_y", alu_y, 4'h0);
    chk("rst_f0", {3'b0, alu_f0}, 4'h1);
    chk("rst_seq_y", seq_y, 4'h0);
    chk("rst_seq_cout", {3'b0, seq_cout}, 4'h0);

    // D0 write through F->B, then read back as 0B
    alu_set(3'd7, 3'd0, 3'd3, 4'd0, 4'd2, 4'd5, 1'b0);
    #1 chk("d0_y", alu_y, 4'h5);
    tick();
    read_b("rd_b2", 4'd2, 4'h5);

    write_ram(4'd1, 4'h9);
    write_ram(4'd3, 4'h3);
    write_ram(4'd4, 4'hB);
    write_q(4'h8);

    // Combinational ALU vectors
    for (int i = 0; i < NVEC; i++) begin
      alu_set(vecs[i].src, vecs[i].op, vecs[i].dest, vecs[i].a, vecs[i].b, vecs[i].din, vecs[i].cin);
      #1;
      chk($sformatf("vec%0d_y", i), alu_y, vecs[i].y);
      chk($sformatf("vec%0d_flags", i), {alu_cout, alu_f0, alu_f3, alu_ovr}, vecs[i].flags);
      chk($sformatf("vec%0d_shift", i), {q3_out, q0_out, ram3_out, ram0_out}, vecs[i].sh);
    end
    alu_dest = 3'd1;

    // RAM shift down / up
    alu_set(3'd7, 3'd0, 3'd5, 4'd0, 4'd5, 4'hB, 1'b0);
    ram3_in = 1'b1;
    #1 chk("dn_ram0_out", {3'b0, ram0_out}, 4'h1);
    tick();
    ram3_in = 1'b0;
    read_b("dn_b", 4'd5, 4'hD);
    alu_set(3'd7, 3'd0, 3'd7, 4'd0, 4'd5, 4'hB, 1'b0);
    ram0_in = 1'b0;
    #1 chk("up_ram3_out", {3'b0, ram3_out}, 4'h1);
    tick();
    read_b("up_b", 4'd5, 4'h6);

    // Q shift down then up
    alu_set(3'd7, 3'd0, 3'd4, 4'd0, 4'd15, 4'h0, 1'b0);
    q3_in = 1'b1;
    tick();
    q3_in = 1'b0;
    read_q("q_dn", 4'hC);
    alu_set(3'd7, 3'd0, 3'd6, 4'd0, 4'd15, 4'h0, 1'b0);
    q0_in = 1'b1;
    tick();
    q0_in = 1'b0;
    read_q("q_up", 4'h9);

    // Incrementer and carry out
    set_seq_s(2'd3); seq_din = 4'hE; seq_cin = 1'b1;
    #1 chk("seq_d", seq_y, 4'hE);
    tick();
    set_seq_s(2'd0);
    #1 chk("seq_upc_f", seq_y, 4'hF);
    chk("seq_cout", {3'b0, seq_cout}, 4'h1);
    tick();
    seq_cin = 1'b0;
    #1 chk("seq_upc_wrap", seq_y, 4'h0);

    // Zero forces Y low
    set_seq_s(2'd3); seq_din = 4'hF; seq_cin = 1'b1; seq_zero_n = 1'b0;
    #1 chk("seq_zero", seq_y, 4'h0);
    chk("seq_zero_cout", {3'b0, seq_cout}, 4'h0);
    seq_zero_n = 1'b1; seq_cin = 1'b0; set_seq_s(2'd0);

    // Push uPC=3, read top, pop, wrap the stack pointer
    set_seq_s(2'd3); seq_din = 4'h3;
    tick();
    set_seq_s(2'd0); seq_fe_n = 1'b0; seq_pup = 1'b1;
    tick();
    seq_fe_n = 1'b1; set_seq_s(2'd2);
    #1 chk("stk_top_push", seq_y, 4'h3);
    seq_fe_n = 1'b0; seq_pup = 1'b0;
    tick();
    seq_fe_n = 1'b1;
    #1 chk("stk_top_pop", seq_y, 4'h0);
    seq_fe_n = 1'b0;
    tick();
    tick();
    tick();
    seq_fe_n = 1'b1;
    #1 chk("stk_wrap", seq_y, 4'h3);

    // Push while reading top shows old top; new entry is previous uPC
    set_seq_s(2'd3); seq_din = 4'h7;
    tick();
    set_seq_s(2'd2); seq_fe_n = 1'b0; seq_pup = 1'b1;
    #1 chk("push_old_top", seq_y, 4'h3);
    tick();
    seq_fe_n = 1'b1;
    #1 chk("push_new_top", seq_y, 4'h7);

    // AR load source
    set_seq_s(2'd0); seq_din = 4'h6; seq_rin = 4'hA; seq_re_n = 1'b0;
    tick();
    seq_re_n = 1'b1; set_seq_s(2'd1);
    #1 chk("ar_load", seq_y, exp_ar);

    // OR inputs
    set_seq_s(2'd3); seq_din = 4'h8; seq_orin = 4'h1;
    #1 chk("or_in", seq_y, exp_or);
    seq_orin = 4'h0;

    // Reset wins over simultaneous writes and stack ops
    alu_set(3'd7, 3'd0, 3'd0, 4'd0, 4'd1, 4'hF, 1'b0);
    seq_fe_n = 1'b0; seq_pup = 1'b1; seq_re_n = 1'b0; seq_din = 4'hF;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seq_fe_n = 1'b1; seq_re_n = 1'b1;
    read_b("rst2_ram1", 4'd1, 4'h0);
    read_b("rst2_ram4", 4'd4, 4'h0);
    read_q("rst2_q", 4'h0);
    set_seq_s(2'd2);
    #1 chk("rst2_stack", seq_y, 4'h0);
    set_seq_s(2'd1);
    #1 chk("rst2_ar", seq_y, 4'h0);
    set_seq_s(2'd0);
    #1 chk("rst2_upc", seq_y, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
